seq_det_scheduler: RTL and testbench

- Time-shares one serial pattern-detector core between N_REQ requesters.
- Each requester presents a parallel frame. The scheduler grants requesters round-robin, serialises the granted frame MSB-first into the detector, counts detector hits, and returns the count with a one-cycle done strobe.
- Sits between the bus-side frame sources and the bit-serial detector datapath.

---
 rtl/seq_det_pkg.sv | 45 ++++
 rtl/seq_det_core.sv | 34 +++
 rtl/seq_det_scheduler.sv | 131 +++++++++++++
 tb/tb_seq_det_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, default sizes and the round-robin selection helper used by
// the sequence-detector scheduler.
package seq_det_pkg;

    // Upper bound on the requester count; the arbiter helper works on this width.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    // Default block sizing.
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_FRAME_W = 16;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Rotate-and-priority-encode: return the first asserted request at or
    // after index (last+1) mod n. If nothing is requested, 'last' is returned
    // and the caller must not act on it.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] req_vec,
        input logic [IDX_W-1:0]   last,
        input int                 n
    );
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        logic             found;
        sel   = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= n && !found) begin
                cand = IDX_W'((int'(last) + i) % n);
                if (req_vec[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial pattern detector. Keeps the last two input bits and flags a hit
// when the current bit and the previous bit are both 1, or when the bit two
// back is 1 and the previous bit is 0. Overlapping hits are reported.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    // hist_q[0] is b(t-1), hist_q[1] is b(t-2).
    logic [1:0] hist_q;

    // History register: cleared at frame start, advanced once per serial bit.
    // NOTE: state is updated with non-blocking assignments so every register
    // in the design samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 2'b00;
        end else if (clr) begin
            hist_q <= 2'b00;
        end else if (en) begin
            hist_q <= {hist_q[0], bit_in};
        end
    end

    // Mealy hit from the current bit and the stored history.
    assign hit = (bit_in & hist_q[0]) | (hist_q[1] & ~hist_q[0]);

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that time-shares one serial pattern detector between
// N_REQ requesters. A granted frame is shifted MSB-first through the detector,
// hits are counted, and the count is returned with a one-cycle done strobe.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   frame_data,
    output logic [N_REQ-1:0]           gnt,
    output logic                       busy,
    output logic [N_REQ-1:0]           done,
    output logic [CNT_W-1:0]           hit_count
);

    // Requester 0 has highest priority after reset, so the pointer starts at
    // the last index.
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);

    state_e               state_q;
    logic [FRAME_W-1:0]   shreg_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     hit_count_q;
    logic [N_REQ-1:0]     gnt_q;
    logic [N_REQ-1:0]     done_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic [IDX_W-1:0]     last_grant_q;

    logic [IDX_W-1:0]     sel_idx;
    logic [FRAME_W-1:0]   frame_sel;
    logic [N_REQ-1:0]     gnt_onehot;
    logic [CNT_W-1:0]     cnt_next;
    logic                 det_clr;
    logic                 det_en;
    logic                 det_bit;
    logic                 det_hit;

    // Arbitration and frame selection for the requester that would be granted.
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_idx    = rr_next(MAX_REQ'(req), last_grant_q, N_REQ);
        frame_sel  = '0;
        gnt_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                frame_sel     = frame_data[i*FRAME_W +: FRAME_W];
                gnt_onehot[i] = 1'b1;
            end
        end
    end

    // Detector hookup: history is held clear while idle, advanced while shifting.
    assign det_clr  = (state_q == IDLE);
    assign det_en   = (state_q == SHIFT);
    assign det_bit  = shreg_q[FRAME_W-1];
    assign cnt_next = cnt_q + {{(CNT_W-1){1'b0}}, det_hit};

    seq_det_core u_core (
        .clk    (clk),
        .reset  (reset),
        .clr    (det_clr),
        .en     (det_en),
        .bit_in (det_bit),
        .hit    (det_hit)
    );

    // Scheduler FSM: grant in IDLE, serialise in SHIFT, strobe done in REPORT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            cnt_q        <= '0;
            hit_count_q  <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            gnt_idx_q    <= '0;
            last_grant_q <= PTR_RESET;
        end else begin
            case (state_q)
                IDLE: begin
                    gnt_q  <= '0;
                    done_q <= '0;
                    if (|req) begin
                        shreg_q   <= frame_sel;
                        gnt_q     <= gnt_onehot;
                        gnt_idx_q <= sel_idx;
                        bit_cnt_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q   <= {shreg_q[FRAME_W-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    cnt_q     <= cnt_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        done_q      <= gnt_q;
                        hit_count_q <= cnt_next;
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    gnt_q        <= '0;
                    done_q       <= '0;
                    last_grant_q <= gnt_idx_q;
                    state_q      <= IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    done_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign hit_count = hit_count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler (N_REQ=4, FRAME_W=16). Inputs are
// driven and outputs sampled 1 time unit after the rising edge.
module tb_seq_det_scheduler;

    localparam int N_REQ   = 4;
    localparam int FRAME_W = 16;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    logic                     clk;
    logic                     reset;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*FRAME_W-1:0] frame_data;
    logic [N_REQ-1:0]         gnt;
    logic                     busy;
    logic [N_REQ-1:0]         done;
    logic [CNT_W-1:0]         hit_count;

    int checks = 0;
    int errors = 0;

    seq_det_scheduler #(
        .N_REQ   (N_REQ),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .frame_data (frame_data),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .hit_count  (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    // Full transaction; caller has set req before the granting edge.
    task automatic serve(input string tag, input logic [3:0] exp_gnt,
                         input logic [4:0] exp_hit, input bit drop);
        step(1);
        check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        if (drop) req = '0;
        step(15);
        check({tag, ".early_done"}, 32'(done), 32'd0);
        step(1);
        check({tag, ".done"}, 32'(done), 32'(exp_gnt));
        check({tag, ".hits"}, 32'(hit_count), 32'(exp_hit));
        check({tag, ".gnt_rep"}, 32'(gnt), 32'(exp_gnt));
        step(1);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check({tag, ".idle_gnt"}, 32'(gnt), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".held_hits"}, 32'(hit_count), 32'(exp_hit));
    endtask

    initial begin
        reset      = 1'b0;
        req        = '0;
        frame_data = '0;
        step(2);
        check("rst.gnt", 32'(gnt), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.hits", 32'(hit_count), 32'd0);
        reset = 1'b1;
        step(1);
        check("idle.busy", 32'(busy), 32'd0);

        // req[2], all-ones frame: 15 hits; frame changes mid-frame are ignored.
        frame_data[2*FRAME_W +: FRAME_W] = 16'hFFFF;
        req = 4'b0100;
        step(1);
        check("t1.gnt", 32'(gnt), 32'b0100);
        req = '0;
        frame_data[2*FRAME_W +: FRAME_W] = 16'h0000;
        step(15);
        check("t1.early_done", 32'(done), 32'd0);
        check("t1.gnt_hold", 32'(gnt), 32'b0100);
        step(1);
        check("t1.done", 32'(done), 32'b0100);
        check("t1.hits", 32'(hit_count), 32'd15);
        step(1);
        check("t1.idle_done", 32'(done), 32'd0);
        check("t1.idle_gnt", 32'(gnt), 32'd0);
        check("t1.held_hits", 32'(hit_count), 32'd15);

        // All-zero frame on req[1]: no hits.
        frame_data[1*FRAME_W +: FRAME_W] = 16'h0000;
        req = 4'b0010;
        serve("zero", 4'b0010, 5'd0, 1'b1);

        // 16'hA000 on req[0]: hits at bit indices 2 and 4.
        frame_data[0*FRAME_W +: FRAME_W] = 16'hA000;
        req = 4'b0001;
        serve("a000", 4'b0001, 5'd2, 1'b1);

        // Fairness from a fresh pointer with all requests held.
        do_reset();
        frame_data[0*FRAME_W +: FRAME_W] = 16'hFFFF;  // 15 hits
        frame_data[1*FRAME_W +: FRAME_W] = 16'h0000;  // 0 hits
        frame_data[2*FRAME_W +: FRAME_W] = 16'hA000;  // 2 hits
        frame_data[3*FRAME_W +: FRAME_W] = 16'h8000;  // 1 hit (bit index 2)
        req = 4'b1111;
        serve("rr0", 4'b0001, 5'd15, 1'b0);
        serve("rr1", 4'b0010, 5'd0,  1'b0);
        serve("rr2", 4'b0100, 5'd2,  1'b0);
        serve("rr3", 4'b1000, 5'd1,  1'b0);
        serve("rr0b", 4'b0001, 5'd15, 1'b1);

        // Single requester held high: re-granted after one idle cycle.
        req = 4'b0010;
        serve("b2b_a", 4'b0010, 5'd0, 1'b0);
        serve("b2b_b", 4'b0010, 5'd0, 1'b1);

        // req[0] dropped at bit 3; frame 16'hC3C3 gives 7 hits.
        frame_data[0*FRAME_W +: FRAME_W] = 16'hC3C3;
        req = 4'b0001;
        step(1);
        check("drop.gnt", 32'(gnt), 32'b0001);
        step(3);
        req = '0;
        step(12);
        check("drop.early_done", 32'(done), 32'd0);
        check("drop.gnt_hold", 32'(gnt), 32'b0001);
        step(1);
        check("drop.done", 32'(done), 32'b0001);
        check("drop.hits", 32'(hit_count), 32'd7);
        step(1);
        check("drop.idle_done", 32'(done), 32'd0);

        // Reset asserted during bit 7 of a req[3] frame.
        frame_data[3*FRAME_W +: FRAME_W] = 16'hFFFF;
        req = 4'b1000;
        step(1);
        check("mrst.gnt", 32'(gnt), 32'b1000);
        step(7);
        reset = 1'b0;
        #2;
        check("mrst.async_gnt", 32'(gnt), 32'd0);
        check("mrst.async_busy", 32'(busy), 32'd0);
        check("mrst.async_done", 32'(done), 32'd0);
        check("mrst.async_hits", 32'(hit_count), 32'd0);
        step(1);
        check("mrst.held_busy", 32'(busy), 32'd0);
        req = 4'b1001;
        reset = 1'b1;
        serve("mrst_r0", 4'b0001, 5'd7, 1'b1);

        // With only req[3] pending after reset, it is served first.
        do_reset();
        req = 4'b1000;
        serve("mrst_r3", 4'b1000, 5'd15, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
